uart_rx_frame: RTL
==================

# uart_rx_frame

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver. It adds configurable data width, one or two stop bits, optional parity checking, and a synchronised serial input. It also adds a one-deep output holding register with a valid/ready handshake plus framing, parity and overrun error reporting. It sits between the pad-side serial line and the byte-stream consumer (FIFO or register bank).

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 19200, line rate in bits/s; DIV = CLK_FREQ/BAUD_RATE (integer divide), DIV ≥ 4 required
- DATA_BITS, 8, data bits per frame, legal 5..9
- STOP_BITS, 1, stop bits checked, legal 1 or 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored unless UART_RX_PARITY_EN is defined
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  received word, LSB first on line; held stable while rx_valid=1
- rx_valid  output  1  holding register full
- rx_ready  input  1  consumer accepts word when rx_valid & rx_ready
- frame_err  output  1  qualifies current rx_data: a stop bit sampled 0
- parity_err  output  1  qualifies current rx_data: parity mismatch (tied 0 without macro)
- overrun  output  1  one-cycle pulse: completed frame dropped because the holding register was full

## Operation
- rx passes a 2-flop synchroniser (reset value 1) to give rx_s; a third flop gives rx_d for edge detection.
- Bit counter clk_div is $clog2(DIV) bits wide; bit index is $clog2(DATA_BITS) bits wide.
- FSM states are IDLE, START, DATA, PARITY, STOP, DONE:
  - IDLE: clear clk_div and index; go to START on a falling edge (rx_d=1, rx_s=0). A line held low never restarts reception.
  - START: count to (DIV-1)/2. If rx_s=0, clear clk_div and go to DATA. Otherwise it is a glitch: return to IDLE with no error.
  - DATA: at clk_div=DIV-1, sample rx_s into shift[index] and clear clk_div. After bit DATA_BITS-1, go to PARITY if the macro is defined, else STOP.
  - PARITY: at DIV-1, sample the parity bit and compute the mismatch flag, then go to STOP.
  - STOP: at each DIV-1, sample the stop bit. Any 0 sets the frame error flag. After STOP_BITS samples, go to DONE.
  - DONE: one cycle.
    - If the holding register is empty, or is being read this cycle (rx_valid & rx_ready), load rx_data and the flags and set rx_valid.
    - Otherwise drop the frame and pulse overrun.
    - Then go to IDLE.
- A consumer read and a DONE load in the same cycle are legal: the new word replaces the old one, rx_valid stays 1, and there is no overrun.
- frame_err and parity_err change only when rx_data loads.
- Reset mid-frame: the FSM returns to IDLE and the partial frame is discarded.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0.

## Timing
- The start bit is confirmed (DIV-1)/2+1 cycles after the falling edge reaches rx_s. The synchroniser adds 2 cycles from the rx pin.
- Each later sample is DIV cycles apart, landing at mid-bit.
- rx_valid rises the cycle after DONE: the last stop-bit sample, plus 1 cycle to DONE, plus 1 cycle.
- The receiver is back in IDLE in the DONE+1 cycle, roughly half a bit before the stop bit ends, so back-to-back frames are caught.
- rx_valid falls the cycle after a handshake, unless a new word loads in that same cycle.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state exists and one parity bit is expected after the data bits.
  - Parity is even or odd per PARITY_ODD.
  - parity_err reports a mismatch.
- UART_RX_PARITY_EN undefined:
  - There is no PARITY state; frames are DATA_BITS + STOP_BITS.
  - parity_err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the rx_state_e enum (3 bits);
  - a helper function for the $clog2(DIV) counter width;
  - the PAR_EVEN/PAR_ODD constants.
- Sub-module uart_sync2 is the 2-flop synchroniser with a parametrised reset value, reusable by other UART blocks.

## Test plan
All scenarios use CLK_FREQ=1000000 and BAUD_RATE=100000, so DIV=10.
- 8N1, byte 0xA5, rx_ready=1 -> rx_valid pulses for 1 cycle, rx_data=0xA5, frame_err=0, parity_err=0.
- 8E1 with macro, frame 0x37 with wrong parity bit 0 -> rx_data=0x37, parity_err=1. Repeating with correct parity 1 -> parity_err=0.
- STOP_BITS=2, byte 0x5A with second stop bit 0 -> rx_data=0x5A, frame_err=1.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses for 1 cycle at the second DONE. Then raise rx_ready -> rx_valid drops next cycle.
- Low glitch of 3 cycles on an idle line -> stays in IDLE, rx_valid stays 0, no errors.
- Assert rst mid-DATA of 0xFF, release, send 0x0F -> only 0x0F is delivered, and all outputs are 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Width of the per-bit clock divider; never narrower than one bit.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with selectable reset value
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receiver with holding register; UART_RX_PARITY_EN enables the parity bit
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = div_width(DIV);
    localparam int IW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'((DIV - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    rx_state_e state_q, state_d;
    logic [CW-1:0]        clk_div_q, clk_div_d;
    logic [IW-1:0]        index_q, index_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s, rx_d_q;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
    logic perr_q, perr_d;
    logic parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        clk_div_d   = clk_div_q;
        index_d     = index_q;
        shift_d     = shift_q;
        ferr_d      = ferr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                clk_div_d = '0;
                index_d   = '0;
                ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_d    = 1'b0;
`endif
                if (rx_d_q && !rx_s) state_d = START;
            end
            START: begin
                // Mid-start-bit recheck rejects short low glitches silently.
                if (clk_div_q == HALF) begin
                    clk_div_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_div_d = clk_div_q + CW'(1);
                end
            end
            DATA: begin
                if (clk_div_q == LAST) begin
                    clk_div_d        = '0;
                    shift_d[index_q] = rx_s;
                    if (index_q == IW'(DATA_BITS - 1)) begin
                        index_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        index_d = index_q + IW'(1);
                    end
                end else begin
                    clk_div_d = clk_div_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_div_q == LAST) begin
                    clk_div_d = '0;
                    perr_d    = (^shift_q) ^ rx_s ^ PAR_SENSE;
                    state_d   = STOP;
                end else begin
                    clk_div_d = clk_div_q + CW'(1);
                end
            end
`endif
            STOP: begin
                // index is reused here as the stop-bit counter.
                if (clk_div_q == LAST) begin
                    clk_div_d = '0;
                    if (!rx_s) ferr_d = 1'b1;
                    if (index_q == IW'(STOP_BITS - 1)) state_d = DONE;
                    else index_d = index_q + IW'(1);
                end else begin
                    clk_div_d = clk_div_q + CW'(1);
                end
            end
            DONE: begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_d   = shift_q;
                    rx_valid_d  = 1'b1;
                    frame_err_d = ferr_q;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = perr_q;
`endif
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_div_q   <= '0;
            index_q     <= '0;
            shift_q     <= '0;
            ferr_q      <= 1'b0;
            rx_d_q      <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_div_q   <= clk_div_d;
            index_q     <= index_d;
            shift_q     <= shift_d;
            ferr_q      <= ferr_d;
            rx_d_q      <= rx_s;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
